// File: rtl/wfifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write side (wclk domain).
// Optional packet-lock mode selected by the WARB_PKT_LOCK_EN define.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; the round-robin pick is granted on the next edge
// OWN   | grant_id owns the write port; beats pass straight through
module wfifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DSIZE     = 8,
   parameter int MAX_BEATS = 64
) (
   input  logic                    wclk,
   input  logic                    wrst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_last,
   input  logic [NREQ*DSIZE-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    wfull,
   output logic                    winc,
   output logic [DSIZE-1:0]        wdata,
   output logic                    grant_vld,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    pkt_err
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   grant_id_nxt;
   logic            grant_vld_nxt;
   logic [IW-1:0]   rr_last, rr_last_nxt;
   logic            own_valid;
   logic            own_last;
   logic [DSIZE-1:0] own_data;
   logic [NREQ-1:0] own_onehot;
   logic            accept;
   logic            release_evt;
   logic [IW:0]     pick_idle;
   logic [IW:0]     pick_rel;

   // Search base+1 upward with wrap; base itself is considered last.
   // Returns {found, index}.
   function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IW-1:0]   base);
      logic          found;
      logic [IW-1:0] idx;
      int            j;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(base) + k) % NREQ;
         if (!found && v[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      own_valid  = 1'b0;
      own_last   = 1'b0;
      own_data   = '0;
      own_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == IW'(i)) begin
            own_valid     = req_valid[i];
            own_last      = req_last[i];
            own_data      = req_data[i*DSIZE +: DSIZE];
            own_onehot[i] = 1'b1;
         end
      end
   end

   assign accept    = (state == S_OWN) & own_valid & ~wfull;
   assign winc      = accept;
   assign wdata     = accept ? own_data : '0;
   assign req_ready = ((state == S_OWN) && !wfull) ? own_onehot : '0;

`ifdef WARB_PKT_LOCK_EN
   localparam int BW = $clog2(MAX_BEATS);

   logic [BW-1:0] beat_cnt;
   logic          at_limit;

   assign at_limit    = (beat_cnt == BW'(MAX_BEATS - 1));
   assign release_evt = accept & (own_last | at_limit);

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         beat_cnt <= '0;
         pkt_err  <= 1'b0;
      end else begin
         if (release_evt)
            beat_cnt <= '0;
         else if (accept)
            beat_cnt <= beat_cnt + 1'b1;
         pkt_err <= accept & at_limit & ~own_last;
      end
   end
`else
   logic unused_last;

   assign unused_last = ^{req_last, own_last};
   assign release_evt = accept;
   assign pkt_err     = 1'b0;
`endif

   always_comb begin
      state_nxt     = state;
      grant_id_nxt  = grant_id;
      grant_vld_nxt = grant_vld;
      rr_last_nxt   = rr_last;
      pick_idle     = rr_pick(req_valid, rr_last);
      pick_rel      = rr_pick(req_valid, grant_id);
      case (state)
         S_IDLE: begin
            if (pick_idle[IW]) begin
               state_nxt     = S_OWN;
               grant_id_nxt  = pick_idle[IW-1:0];
               grant_vld_nxt = 1'b1;
            end
         end
         S_OWN: begin
            if (release_evt) begin
               rr_last_nxt = grant_id;
               if (pick_rel[IW]) begin
                  grant_id_nxt = pick_rel[IW-1:0];
               end else begin
                  state_nxt     = S_IDLE;
                  grant_vld_nxt = 1'b0;
               end
            end
         end
         default: begin
            state_nxt     = S_IDLE;
            grant_vld_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state     <= S_IDLE;
         grant_vld <= 1'b0;
         grant_id  <= '0;
         rr_last   <= IW'(NREQ - 1);
      end else begin
         state     <= state_nxt;
         grant_vld <= grant_vld_nxt;
         grant_id  <= grant_id_nxt;
         rr_last   <= rr_last_nxt;
      end
   end

endmodule

// File: tb/tb_wfifo_wr_arbiter.sv
// Directed bench for wfifo_wr_arbiter; lock-mode scenarios build only with WARB_PKT_LOCK_EN.
module tb_wfifo_wr_arbiter;

   logic        wclk;
   logic        wrst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        wfull;
   logic        winc;
   logic [7:0]  wdata;
   logic        grant_vld;
   logic [1:0]  grant_id;
   logic        pkt_err;

   int checks   = 0;
   int failures = 0;

   wfifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAX_BEATS(4)) dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .grant_vld (grant_vld),
      .grant_id  (grant_id),
      .pkt_err   (pkt_err)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      wfull     = 1'b0;
      wrst_n    = 1'b0;
      tick();
      wrst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] pat [4] = '{4'b1111, 4'b0101, 4'b1010, 4'b0001};
      wrst_n = 1'b0;
      wfull  = 1'b0;
      req_last = 4'b1111;
      req_data = 32'hA3A2A1A0;
      for (int i = 0; i < 4; i++) begin
         req_valid = pat[i];
         #1;
         checks++; if (winc !== 1'b0) begin failures++; $display("FAIL rst_winc[%0d] got=%b exp=0", i, winc); end
         checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready[%0d] got=%b exp=0000", i, req_ready); end
         checks++; if (grant_vld !== 1'b0) begin failures++; $display("FAIL rst_grant_vld[%0d] got=%b exp=0", i, grant_vld); end
         checks++; if (pkt_err !== 1'b0) begin failures++; $display("FAIL rst_pkt_err[%0d] got=%b exp=0", i, pkt_err); end
         checks++; if (wdata !== 8'h00) begin failures++; $display("FAIL rst_wdata[%0d] got=%h exp=00", i, wdata); end
         tick();
      end
      checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
   endtask

   task automatic test_round_robin();
      logic [1:0] e;
      do_reset();
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      req_data  = 32'hA3A2A1A0;
      #1;
      checks++; if (winc !== 1'b0) begin failures++; $display("FAIL rr_idle_winc got=%b exp=0", winc); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rr_idle_ready got=%b exp=0000", req_ready); end
      tick();
      for (int i = 0; i < 5; i++) begin
         e = 2'(i % 4);
         checks++; if (grant_vld !== 1'b1) begin failures++; $display("FAIL rr_grant_vld[%0d] got=%b exp=1", i, grant_vld); end
         checks++; if (grant_id !== e) begin failures++; $display("FAIL rr_grant_id[%0d] got=%0d exp=%0d", i, grant_id, e); end
         checks++; if (winc !== 1'b1) begin failures++; $display("FAIL rr_winc[%0d] got=%b exp=1", i, winc); end
         checks++; if (wdata !== 8'hA0 + 8'(e)) begin failures++; $display("FAIL rr_wdata[%0d] got=%h exp=%h", i, wdata, 8'hA0 + 8'(e)); end
         checks++; if (req_ready !== 4'(1 << e)) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, 4'(1 << e)); end
         tick();
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      req_valid = 4'b0100;
      req_last  = 4'b0000;
      req_data[16 +: 8] = 8'h21;
      tick();
      checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL st_grant_id got=%0d exp=2", grant_id); end
      checks++; if (winc !== 1'b1) begin failures++; $display("FAIL st_first_winc got=%b exp=1", winc); end
      checks++; if (wdata !== 8'h21) begin failures++; $display("FAIL st_first_wdata got=%h exp=21", wdata); end
      tick();
      req_data[16 +: 8] = 8'h22;
      wfull = 1'b1;
      for (int k = 0; k < 5; k++) begin
         req_valid = (k == 2) ? 4'b0000 : 4'b0100;
         #1;
         checks++; if (winc !== 1'b0) begin failures++; $display("FAIL st_winc[%0d] got=%b exp=0", k, winc); end
         checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL st_ready[%0d] got=%b exp=0000", k, req_ready); end
         checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL st_hold_id[%0d] got=%0d exp=2", k, grant_id); end
         checks++; if (grant_vld !== 1'b1) begin failures++; $display("FAIL st_hold_vld[%0d] got=%b exp=1", k, grant_vld); end
         tick();
      end
      wfull = 1'b0;
      req_valid = 4'b0100;
      #1;
      checks++; if (winc !== 1'b1) begin failures++; $display("FAIL st_resume_winc got=%b exp=1", winc); end
      checks++; if (wdata !== 8'h22) begin failures++; $display("FAIL st_resume_wdata got=%h exp=22", wdata); end
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL st_resume_ready got=%b exp=0100", req_ready); end
      tick();
      req_data[16 +: 8] = 8'h23;
      req_last = 4'b0100;
      #1;
      checks++; if (wdata !== 8'h23) begin failures++; $display("FAIL st_next_wdata got=%h exp=23", wdata); end
      tick();
      req_valid = '0;
      req_last  = '0;
   endtask

`ifndef WARB_PKT_LOCK_EN
   task automatic test_no_lock();
      int         cnt0, cnt1;
      logic [1:0] es;
      logic [7:0] ed;
      do_reset();
      cnt0 = 0;
      cnt1 = 0;
      req_valid = 4'b0011;
      req_last  = 4'b0000;
      req_data[0 +: 8] = 8'h01;
      req_data[8 +: 8] = 8'h11;
      tick();
      for (int i = 0; i < 6; i++) begin
         req_valid[0] = (cnt0 < 3);
         req_valid[1] = (cnt1 < 3);
         req_last[0]  = (cnt0 == 2);
         req_last[1]  = (cnt1 == 2);
         req_data[0 +: 8] = 8'h01 + 8'(cnt0);
         req_data[8 +: 8] = 8'h11 + 8'(cnt1);
         #1;
         es = 2'(i % 2);
         ed = (es == 2'd1) ? 8'h11 + 8'(i / 2) : 8'h01 + 8'(i / 2);
         checks++; if (grant_id !== es) begin failures++; $display("FAIL nl_grant_id[%0d] got=%0d exp=%0d", i, grant_id, es); end
         checks++; if (winc !== 1'b1) begin failures++; $display("FAIL nl_winc[%0d] got=%b exp=1", i, winc); end
         checks++; if (wdata !== ed) begin failures++; $display("FAIL nl_wdata[%0d] got=%h exp=%h", i, wdata, ed); end
         checks++; if (pkt_err !== 1'b0) begin failures++; $display("FAIL nl_pkt_err[%0d] got=%b exp=0", i, pkt_err); end
         if (es == 2'd0) cnt0++; else cnt1++;
         tick();
      end
      req_valid = '0;
      #1;
      checks++; if (winc !== 1'b0) begin failures++; $display("FAIL nl_done_winc got=%b exp=0", winc); end
      tick();
   endtask
`else
   task automatic test_lock();
      do_reset();
      req_valid = 4'b0011;
      req_last  = 4'b0010;
      req_data[8 +: 8] = 8'h55;
      req_data[0 +: 8] = 8'h01;
      tick();
      for (int i = 0; i < 3; i++) begin
         req_data[0 +: 8] = 8'h01 + 8'(i);
         req_last[0] = (i == 2);
         #1;
         checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL lk_grant_id[%0d] got=%0d exp=0", i, grant_id); end
         checks++; if (winc !== 1'b1) begin failures++; $display("FAIL lk_winc[%0d] got=%b exp=1", i, winc); end
         checks++; if (wdata !== 8'h01 + 8'(i)) begin failures++; $display("FAIL lk_wdata[%0d] got=%h exp=%h", i, wdata, 8'h01 + 8'(i)); end
         tick();
      end
      req_valid[0] = 1'b0;
      req_last[0]  = 1'b0;
      #1;
      checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL lk_handoff_id got=%0d exp=1", grant_id); end
      checks++; if (winc !== 1'b1) begin failures++; $display("FAIL lk_handoff_winc got=%b exp=1", winc); end
      checks++; if (wdata !== 8'h55) begin failures++; $display("FAIL lk_handoff_wdata got=%h exp=55", wdata); end
      tick();
      req_valid = '0;
   endtask

   task automatic test_overrun();
      do_reset();
      req_valid = 4'b0011;
      req_last  = 4'b0010;
      req_data[8 +: 8] = 8'h77;
      req_data[0 +: 8] = 8'h41;
      tick();
      for (int i = 0; i < 4; i++) begin
         req_data[0 +: 8] = 8'h41 + 8'(i);
         #1;
         checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL ov_grant_id[%0d] got=%0d exp=0", i, grant_id); end
         checks++; if (wdata !== 8'h41 + 8'(i)) begin failures++; $display("FAIL ov_wdata[%0d] got=%h exp=%h", i, wdata, 8'h41 + 8'(i)); end
         checks++; if (pkt_err !== 1'b0) begin failures++; $display("FAIL ov_pkt_err_pre[%0d] got=%b exp=0", i, pkt_err); end
         tick();
      end
      req_data[0 +: 8] = 8'h45;
      #1;
      checks++; if (pkt_err !== 1'b1) begin failures++; $display("FAIL ov_pkt_err got=%b exp=1", pkt_err); end
      checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL ov_new_owner got=%0d exp=1", grant_id); end
      checks++; if (wdata !== 8'h77) begin failures++; $display("FAIL ov_new_wdata got=%h exp=77", wdata); end
      tick();
      req_valid[1] = 1'b0;
      #1;
      checks++; if (pkt_err !== 1'b0) begin failures++; $display("FAIL ov_pkt_err_post got=%b exp=0", pkt_err); end
      checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL ov_back_owner got=%0d exp=0", grant_id); end
      checks++; if (wdata !== 8'h45) begin failures++; $display("FAIL ov_back_wdata got=%h exp=45", wdata); end
      tick();
      req_valid = '0;
   endtask
`endif

   initial begin
      wrst_n    = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      wfull     = 1'b0;
      #2;
      test_reset();
      test_round_robin();
      test_full_stall();
`ifndef WARB_PKT_LOCK_EN
      test_no_lock();
`else
      test_lock();
      test_overrun();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
